// File: rtl/serial_adder.sv
// Multi-cycle adder: SLICE bits per clock, LSB slice first, carry held in a register between slices.
// Optional subtract mode and overflow flag are enabled with `define SERIAL_ADDER_SUB_EN.
module serial_adder #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
    output logic             ovf,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout
);

    localparam int N  = WIDTH / SLICE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] opA_q, opA_d;
    logic [WIDTH-1:0] opB_q, opB_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
`ifdef SERIAL_ADDER_SUB_EN
    logic             ovf_q, ovf_d;
`endif

    int               sliceBase;
    logic [SLICE-1:0] sliceA;
    logic [SLICE-1:0] sliceB;
    logic [SLICE-1:0] sliceSum;
    logic [SLICE:0]   chain;
    logic [WIDTH-1:0] shadowNext;

    assign sliceBase = int'(count_q) * SLICE;
    assign sliceA    = opA_q[sliceBase +: SLICE];
    assign sliceB    = opB_q[sliceBase +: SLICE];
    assign chain[0]  = carry_q;

    // One ripple chain of one-bit full adders, reused for every slice.
    for (genvar i = 0; i < SLICE; i++) begin : g_fa
        assign sliceSum[i]  = sliceA[i] ^ sliceB[i] ^ chain[i];
        assign chain[i + 1] = (sliceA[i] & sliceB[i]) | (chain[i] & (sliceA[i] ^ sliceB[i]));
    end

    always_comb begin
        shadowNext = shadow_q;
        shadowNext[sliceBase +: SLICE] = sliceSum;
    end

    always_comb begin
        state_d  = state_q;
        opA_d    = opA_q;
        opB_d    = opB_q;
        carry_d  = carry_q;
        count_d  = count_q;
        shadow_d = shadow_q;
        sum_d    = sum_q;
        cout_d   = cout_q;
`ifdef SERIAL_ADDER_SUB_EN
        ovf_d    = ovf_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    opA_d   = a;
`ifdef SERIAL_ADDER_SUB_EN
                    // Subtract as a + ~b + 1; the external carry-in is irrelevant here.
                    opB_d   = sub ? ~b : b;
                    carry_d = sub | cin;
`else
                    opB_d   = b;
                    carry_d = cin;
`endif
                    count_d = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                shadow_d = shadowNext;
                carry_d  = chain[SLICE];
                count_d  = count_q + CW'(1);
                if (count_q == CW'(N - 1)) begin
                    sum_d   = shadowNext;
                    cout_d  = chain[SLICE];
`ifdef SERIAL_ADDER_SUB_EN
                    ovf_d   = chain[SLICE] ^ chain[SLICE - 1];
`endif
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            opA_q    <= '0;
            opB_q    <= '0;
            carry_q  <= 1'b0;
            count_q  <= '0;
            shadow_q <= '0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            opA_q    <= opA_d;
            opB_q    <= opB_d;
            carry_q  <= carry_d;
            count_q  <= count_d;
            shadow_q <= shadow_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
`ifdef SERIAL_ADDER_SUB_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign s    = sum_q;
    assign cout = cout_q;
`ifdef SERIAL_ADDER_SUB_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: an arithmetic latency/result model compared every cycle,
// plus directed literal checks and randomized start/operand traffic.
module tb_serial_adder;

    localparam int WIDTH = 32;
    localparam int SLICE = 8;
    localparam int N     = WIDTH / SLICE;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             cin   = 1'b0;
    logic [WIDTH-1:0] a     = '0;
    logic [WIDTH-1:0] b     = '0;
`ifdef SERIAL_ADDER_SUB_EN
    logic             sub   = 1'b0;
    logic             ovf;
`endif
    logic             busy;
    logic             done;
    logic             cout;
    logic [WIDTH-1:0] s;

    int compares = 0;
    int errors   = 0;
    int cyc      = 0;

    serial_adder #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub),
        .ovf   (ovf),
`endif
        .busy  (busy),
        .done  (done),
        .s     (s),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Reference model: on accept, compute the whole sum with plain arithmetic and
    // release it N cycles later; start is ignored while an operation is pending.
    logic             mBusy = 1'b0;
    logic             mDone = 1'b0;
    logic [WIDTH-1:0] mS    = '0;
    logic             mCout = 1'b0;
    logic             mOvf  = 1'b0;
    int               remaining = 0;
    logic [WIDTH-1:0] pendS;
    logic             pendCout;
    logic             pendOvf;
    logic [WIDTH:0]   full;
    logic [WIDTH-1:0] bEff;
    logic             cEff;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mBusy = 1'b0; mDone = 1'b0; mS = '0; mCout = 1'b0; mOvf = 1'b0;
            remaining = 0;
        end else if (remaining > 0) begin
            remaining--;
            mDone = 1'b0;
            if (remaining == 0) begin
                mS = pendS; mCout = pendCout; mOvf = pendOvf;
                mBusy = 1'b0; mDone = 1'b1;
            end
        end else begin
            mDone = 1'b0;
            if (start) begin
`ifdef SERIAL_ADDER_SUB_EN
                bEff = sub ? ~b : b;
                cEff = sub ? 1'b1 : cin;
`else
                bEff = b;
                cEff = cin;
`endif
                full     = {1'b0, a} + {1'b0, bEff} + {{WIDTH{1'b0}}, cEff};
                pendS    = full[WIDTH-1:0];
                pendCout = full[WIDTH];
                pendOvf  = (a[WIDTH-1] == bEff[WIDTH-1]) && (full[WIDTH-1] != a[WIDTH-1]);
                remaining = N;
                mBusy = 1'b1;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compares++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        check("busy", busy, mBusy);
        check("done", done, mDone);
        check("s", s, mS);
        check("cout", cout, mCout);
`ifdef SERIAL_ADDER_SUB_EN
        check("ovf", ovf, mOvf);
`endif
    end

    task automatic applyStimulus(input logic [WIDTH-1:0] opA, input logic [WIDTH-1:0] opB,
                                 input logic c, input logic sb);
        int lat;
        @(negedge clk); #1;
        a = opA; b = opB; cin = c; start = 1'b1;
`ifdef SERIAL_ADDER_SUB_EN
        sub = sb;
`else
        if (sb) $display("[TB] note: sub request ignored in adder-only build");
`endif
        @(negedge clk); #1;
        start = 1'b0;
        a = $urandom; b = $urandom; cin = 1'($urandom);
        lat = -1;
        for (int i = 0; i < N + 4; i++) begin
            @(negedge clk);
            if (done) begin
                lat = i + 1;
                break;
            end
        end
        check("latency", lat, N);
    endtask

    task automatic checkOutput(input string name, input logic [WIDTH-1:0] expS, input logic expC);
        check({name, "_s"}, s, expS);
        check({name, "_cout"}, cout, expC);
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        while ((busy || done) && n < 4 * N + 8) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", busy, 1'b0);
    endtask

    initial begin
        int doneCyc[$];
        int sawDone;

        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checkOutput("reset", '0, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);

        applyStimulus(32'h12345678, 32'h87654321, 1'b0, 1'b0);
        checkOutput("basic", 32'h99999999, 1'b0);

        applyStimulus(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0);
        checkOutput("ripple_b", 32'h00000000, 1'b1);
        applyStimulus(32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0);
        checkOutput("ripple_cin", 32'h00000000, 1'b1);

`ifdef SERIAL_ADDER_SUB_EN
        applyStimulus(32'd5, 32'd7, 1'b0, 1'b1);
        checkOutput("sub_neg", 32'hFFFFFFFE, 1'b0);
        check("sub_neg_ovf", ovf, 1'b0);
        applyStimulus(32'h80000000, 32'd1, 1'b0, 1'b1);
        checkOutput("sub_ovf", 32'h7FFFFFFF, 1'b1);
        check("sub_ovf_ovf", ovf, 1'b1);
        applyStimulus(32'h7FFFFFFF, 32'd1, 1'b0, 1'b0);
        checkOutput("add_ovf", 32'h80000000, 1'b0);
        check("add_ovf_ovf", ovf, 1'b1);
`endif

        // Start held high: operands churn every cycle, only the accepted ones matter.
        @(negedge clk); #1;
        start = 1'b1;
        for (int i = 0; i < 6 * (N + 1) && doneCyc.size() < 4; i++) begin
            @(negedge clk);
            if (done) doneCyc.push_back(cyc);
            #1;
            a = $urandom; b = $urandom; cin = 1'($urandom);
        end
        check("held_done_count", doneCyc.size(), 4);
        for (int i = 1; i < doneCyc.size(); i++)
            check("held_spacing", doneCyc[i] - doneCyc[i-1], N + 1);
        start = 1'b0;
        waitIdle();

        // Randomized traffic, including start pulses while busy.
        for (int i = 0; i < 300; i++) begin
            @(negedge clk); #1;
            start = ($urandom_range(0, 2) == 0);
            a = $urandom; b = $urandom; cin = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
            sub = 1'($urandom);
`endif
        end
        @(negedge clk); #1;
        start = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        sub = 1'b0;
`endif
        waitIdle();

        // Reset during the second RUN cycle aborts the operation.
        applyStimulus(32'd1, 32'd2, 1'b0, 1'b0);
        checkOutput("pre_abort", 32'd3, 1'b0);
        @(negedge clk); #1;
        a = 32'hFFFFFFFF; b = 32'h1; cin = 1'b0; start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        checkOutput("abort", '0, 1'b0);
        @(negedge clk); #1;
        rst_n = 1'b1;
        sawDone = 0;
        for (int i = 0; i < N + 3; i++) begin
            @(negedge clk);
            if (done) sawDone = 1;
        end
        check("abort_no_done", sawDone, 0);
        applyStimulus(32'd3, 32'd4, 1'b0, 1'b0);
        checkOutput("after_abort", 32'd7, 1'b0);

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Parametrised multi-cycle adder: adds two WIDTH-bit operands SLICE bits per clock, LSB slice first, with a registered carry between slices.
- Datapath resource for the team's CPU where a full-width single-cycle carry chain is too slow or too large.
- Start/done handshake.
- Each slice is built from the team's one-bit adder primitives.

Parameters:
- WIDTH, 32, operand and result width in bits; must be >= 1.
- SLICE, 8, bits added per clock; must be >= 1 and divide WIDTH evenly. N = WIDTH/SLICE is the number of slices.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only when not busy
- a  input  WIDTH  operand A; captured on the accepting edge
- b  input  WIDTH  operand B; captured on the accepting edge
- cin  input  1  carry-in; captured on the accepting edge
- busy  output  1  high while slices are being processed
- done  output  1  one-cycle pulse; result valid
- s  output  WIDTH  sum; registered and held until the next result
- cout  output  1  final carry-out; registered and held

Behaviour:
- Reset: async on rst_n low.
  - State IDLE; busy=0, done=0, s=0, cout=0.
  - Internal operand regs, carry reg and slice counter cleared.
  - Reset mid-operation aborts the operation; no done is produced.
- States: IDLE, RUN, DONE.
- IDLE or DONE, start=1 at edge E0:
  - capture a, b, cin; counter=0; state RUN; busy=1.
  - done drops if it was high.
- IDLE or DONE, start=0: DONE goes to IDLE; IDLE holds.
- RUN, edge Ek (k=1..N):
  - Add slice k-1 (bits [(k-1)*SLICE +: SLICE]) plus the carry reg.
  - Write the slice sum into the result shadow; update the carry reg; increment the counter.
- At edge EN:
  - s <= full result; cout <= final carry.
  - state DONE; busy=0; done=1 for the cycle following EN.
- Latency: done is visible N cycles after the accepting edge E0.
- Throughput: one add per N+1 cycles when start is held high, because the next start is accepted in DONE.
- Width rules: operands are unsigned; s = (a + b + cin) mod 2^WIDTH; cout = bit WIDTH of the true sum.
- start while busy=1 is ignored: no queueing, no error. Operands changing while busy have no effect.
- s and cout change only at edge EN and at reset. Intermediate slice sums are never visible on s.
- N=1 (SLICE=WIDTH) is legal: one RUN cycle.
- The counter is sized to hold 0..N-1, with a minimum of 1 bit.

Optional Feature:
- Macro SERIAL_ADDER_SUB_EN.
- Defined: adds input port sub (1 bit) and output port ovf (1 bit, reset 0). Both are captured and updated with the same timing as b and cout.
  - sub=1 at the accepting edge: the captured b is inverted and the captured carry-in is forced to 1, so s = a - b mod 2^WIDTH. cin is ignored in this mode. cout=1 means no borrow.
  - ovf = two's-complement overflow: carry into the MSB XOR carry out of the MSB. Valid for both add and subtract, registered at EN, held with s.
- Undefined: ports sub and ovf do not exist; the block is an adder only.

Test Plan (WIDTH=32, SLICE=8, N=4):
- Reset check: rst_n low then high → busy=0, done=0, s=0, cout=0. Then a=0x12345678, b=0x87654321, cin=0, start 1 cycle → busy high 4 cycles; done pulses once 4 cycles after the accepting edge; s=0x99999999, cout=0.
- Full carry ripple across every slice boundary: a=0xFFFFFFFF, b=0x00000001, cin=0 → s=0x00000000, cout=1. Same with b=0, cin=1 → identical result.
- start held high continuously with new operands each accept → an accept every 5 cycles. Pulses of start during busy are ignored; s is unchanged until the next EN.
- rst_n pulsed low on the second RUN cycle → immediate busy=0, s=0, cout=0; no done follows. A subsequent start completes normally.
- SERIAL_ADDER_SUB_EN cases:
  - a=5, b=7, sub=1 → s=0xFFFFFFFE, cout=0, ovf=0.
  - a=0x80000000, b=1, sub=1 → s=0x7FFFFFFF, ovf=1.
  - a=0x7FFFFFFF, b=1, sub=0 → s=0x80000000, ovf=1.
- SLICE=32 (N=1) build: a=3, b=4 → done 1 cycle after accept, s=7.
